// File: rtl/dm_arbiter.sv
// dm_arbiter: serialises two masters onto the single dm_4k port (IDLE -> ACCESS -> RESP).
// Define DM_ARB_FIXED_PRIO_EN for fixed priority (M0 wins ties); default is round-robin.
module dm_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_we,
    input  logic [DW-1:0] dm_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          sel;
    logic          grant_sel;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

`ifdef DM_ARB_FIXED_PRIO_EN
    assign grant_sel = ~m0_req;
`else
    logic last_grant;

    // On a tie the port that was not served last time wins.
    always_comb begin
        grant_sel = m1_req;
        if (m0_req && m1_req)
            grant_sel = ~last_grant;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (state == ACCESS)
            last_grant <= sel;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        sel       <= grant_sel;
                        lat_we    <= grant_sel ? m1_we    : m0_we;
                        lat_addr  <= grant_sel ? m1_addr  : m0_addr;
                        lat_wdata <= grant_sel ? m1_wdata : m0_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (sel)
                            m1_rdata <= dm_dout;
                        else
                            m0_rdata <= dm_dout;
                    end
                    m0_ack <= ~sel;
                    m1_ack <= sel;
                    state  <= RESP;
                end
                RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Reset gates the write strobe so an access cut short by reset never commits.
    assign dm_we   = (state == ACCESS) && lat_we && !reset;
    assign dm_addr = lat_addr;
    assign dm_din  = lat_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a transaction-level model.
// Honours DM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;
    logic        dm_we;

    dm_arbiter #(.AW(10), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Behaviour of dm_4k: combinational read, write on the clock edge.
    logic [31:0] dmMem [0:1023];
    assign dm_dout = dmMem[dm_addr];
    always @(posedge clk) if (dm_we) dmMem[dm_addr] <= dm_din;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: one outstanding transaction, memory image and expected read registers.
    logic [31:0] refMem [0:1023];
    int          edgeNum = 0;
    int          nextSample = 0;
    int          accessEnd = 0;
    bit          pendValid = 0;
    int          pendPort = 0;
    logic        pendWe;
    logic [9:0]  pendAddr;
    logic [31:0] pendWdata;
    int          lastGrant = 1;
    logic [31:0] expR0 = 0, expR1 = 0;
    bit          inAccess, inResp;

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, edgeNum, obs, exp);
        end
    endtask

    task automatic driveReq(input int p, input logic r, input logic w,
                            input logic [9:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic newCmd(input int p);
        driveReq(p, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), $urandom);
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, then check outputs.
    task automatic stepCycle();
        int w;
        @(posedge clk);
        edgeNum++;
        if (reset) begin
            pendValid  = 0;
            lastGrant  = 1;
            expR0      = 0;
            expR1      = 0;
            nextSample = edgeNum + 1;
        end else begin
            if (pendValid && edgeNum == accessEnd) begin
                if (pendWe)             refMem[pendAddr] = pendWdata;
                else if (pendPort == 0) expR0 = refMem[pendAddr];
                else                    expR1 = refMem[pendAddr];
            end
            if (edgeNum >= nextSample && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = 1 - lastGrant;
`endif
                end else begin
                    w = m1_req ? 1 : 0;
                end
                pendValid  = 1;
                pendPort   = w;
                pendWe     = (w == 1) ? m1_we    : m0_we;
                pendAddr   = (w == 1) ? m1_addr  : m0_addr;
                pendWdata  = (w == 1) ? m1_wdata : m0_wdata;
                accessEnd  = edgeNum + 1;
                nextSample = edgeNum + 3;
                lastGrant  = w;
            end
        end
        #1;
        inAccess = pendValid && (edgeNum == accessEnd - 1);
        inResp   = pendValid && (edgeNum == accessEnd);
        checkOutput("m0_ack", {31'b0, m0_ack}, {31'b0, inResp && pendPort == 0});
        checkOutput("m1_ack", {31'b0, m1_ack}, {31'b0, inResp && pendPort == 1});
        checkOutput("dm_we", {31'b0, dm_we}, {31'b0, inAccess && pendWe && !reset});
        checkOutput("m0_rdata", m0_rdata, expR0);
        checkOutput("m1_rdata", m1_rdata, expR1);
        if (inAccess) begin
            checkOutput("dm_addr", {22'b0, dm_addr}, {22'b0, pendAddr});
            if (pendWe) checkOutput("dm_din", dm_din, pendWdata);
        end
    endtask

    task automatic applyReset();
        driveReq(0, 0, 0, 0, 0);
        driveReq(1, 0, 0, 0, 0);
        reset = 1'b1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
    endtask

    // One complete handshake from an idle arbiter; optionally disturbs the address during ACCESS.
    task automatic applyStimulus(input int p, input logic w, input logic [9:0] a,
                                 input logic [31:0] d, input bit scramble,
                                 output logic [31:0] rd);
        int cyc = 0;
        bit got = 0;
        driveReq(p, 1'b1, w, a, d);
        while (!got && cyc < 20) begin
            stepCycle();
            cyc++;
            if (scramble && inAccess && pendPort == p) begin
                if (p == 0) m0_addr = 10'h008;
                else        m1_addr = 10'h008;
            end
            if ((p == 0) ? m0_ack : m1_ack) got = 1;
        end
        checkOutput("latency", 32'(cyc), 32'd2);
        rd = (p == 0) ? m0_rdata : m1_rdata;
        driveReq(p, 0, 0, 0, 0);
        stepCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int a0, a1;
        int winners[$];

        for (int i = 0; i < 1024; i++) begin
            dmMem[i]  = pat(i);
            refMem[i] = pat(i);
        end
        reset = 1'b0;
        driveReq(0, 0, 0, 0, 0);
        driveReq(1, 0, 0, 0, 0);

        $display("[TB] reset and idle");
        applyReset();
        for (int c = 0; c < 10; c++) stepCycle();

        $display("[TB] M0 write then read 0x004");
        applyStimulus(0, 1'b1, 10'h004, 32'hDEADBEEF, 0, rd);
        applyStimulus(0, 1'b0, 10'h004, 32'h0, 0, rd);
        checkOutput("t2_rdata", rd, 32'hDEADBEEF);

        $display("[TB] address changed during ACCESS");
        applyStimulus(0, 1'b0, 10'h004, 32'h0, 1, rd);
        checkOutput("t6_latched_addr", rd, 32'hDEADBEEF);

        $display("[TB] reset during M1 write ACCESS");
        driveReq(1, 1'b1, 1'b1, 10'h3FF, 32'h12345678);
        stepCycle();
        checkOutput("t5_in_access", {31'b0, inAccess}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t5_we_suppressed", {31'b0, dm_we}, 32'd0);
        driveReq(1, 0, 0, 0, 0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        applyStimulus(1, 1'b0, 10'h3FF, 32'h0, 0, rd);
        checkOutput("t5_rdata", rd, pat(10'h3FF));

        $display("[TB] simultaneous requests after reset");
        applyReset();
        driveReq(0, 1'b1, 1'b0, 10'h010, 32'h0);
        driveReq(1, 1'b1, 1'b0, 10'h020, 32'h0);
        a0 = -1;
        a1 = -1;
        for (int c = 1; c <= 12 && (a0 < 0 || a1 < 0); c++) begin
            stepCycle();
            if (m0_ack) begin
                a0 = c;
                checkOutput("t3_m0_rdata", m0_rdata, pat(10'h010));
                driveReq(0, 0, 0, 0, 0);
            end
            if (m1_ack) begin
                a1 = c;
                checkOutput("t3_m1_rdata", m1_rdata, pat(10'h020));
                driveReq(1, 0, 0, 0, 0);
            end
        end
        checkOutput("t3_m0_ack_cycle", 32'(a0), 32'd2);
        checkOutput("t3_m1_gap", 32'(a1 - a0), 32'd3);

        $display("[TB] continuous requests from both ports");
        applyReset();
        driveReq(0, 1'b1, 1'b0, 10'($urandom_range(0, 15)), 32'h0);
        driveReq(1, 1'b1, 1'b0, 10'($urandom_range(0, 15)), 32'h0);
        for (int c = 1; c <= 15; c++) begin
            stepCycle();
            if (m0_ack) begin
                winners.push_back(0);
                driveReq(0, 1'b1, 1'b0, 10'($urandom_range(0, 15)), 32'h0);
            end
            if (m1_ack) begin
                winners.push_back(1);
                driveReq(1, 1'b1, 1'b0, 10'($urandom_range(0, 15)), 32'h0);
            end
        end
        driveReq(0, 0, 0, 0, 0);
        driveReq(1, 0, 0, 0, 0);
        stepCycle();
        checkOutput("t4_grant_count", 32'(winners.size()), 32'd5);
        for (int k = 0; k < winners.size(); k++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            checkOutput("t4_grant_order", 32'(winners[k]), 32'd0);
`else
            checkOutput("t4_grant_order", 32'(winners[k]), 32'(k % 2));
`endif
        end

        $display("[TB] randomized traffic");
        applyReset();
        for (int c = 0; c < 800; c++) begin
            stepCycle();
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? m0_ack : m1_ack) begin
                    if ($urandom_range(0, 1) == 1) newCmd(p);
                    else driveReq(p, 0, 0, 0, 0);
                end else if (!((p == 0) ? m0_req : m1_req)) begin
                    if ($urandom_range(0, 2) == 0) newCmd(p);
                end else if (inAccess && pendPort == p && $urandom_range(0, 1) == 1) begin
                    newCmd(p);
                end
            end
        end
        for (int c = 0; c < 12; c++) begin
            stepCycle();
            if (m0_ack) driveReq(0, 0, 0, 0, 0);
            if (m1_ack) driveReq(1, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
